// File: rtl/dsd_pkg.sv
// rtl/dsd_pkg.sv - shared constants, store-entry type and FSM encoding for the store write-back stage
package dsd_pkg;

    localparam int DSD_DATA_WIDTH  = 8;
    localparam int DSD_MEM_SIZE    = 64;
    localparam int DSD_QUEUE_DEPTH = 4;

    function automatic int addr_width(input int size);
        return (size > 1) ? $clog2(size) : 1;
    endfunction

    localparam int DSD_AW = addr_width(DSD_MEM_SIZE);

    typedef struct packed {
        logic [DSD_AW-1:0]         addr;
        logic [DSD_DATA_WIDTH-1:0] data;
    } store_entry_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } state_e;

endpackage

// File: rtl/store_queue.sv
// rtl/store_queue.sv - circular pending-store FIFO exposing every slot for address-match forwarding
module store_queue
    import dsd_pkg::*;
#(
    parameter int AW    = DSD_AW,
    parameter int DW    = DSD_DATA_WIDTH,
    parameter int DEPTH = DSD_QUEUE_DEPTH,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push,
    input  logic                      pop,
    input  logic [AW-1:0]             wr_addr,
    input  logic [DW-1:0]             wr_data,
    output logic [AW-1:0]             head_addr,
    output logic [DW-1:0]             head_data,
    output logic [CW-1:0]             count,
    output logic                      full,
    output logic                      empty,
    output logic [PW-1:0]             rd_ptr,
    output logic [DEPTH-1:0]          ent_valid,
    output logic [DEPTH-1:0][AW-1:0]  ent_addr,
    output logic [DEPTH-1:0][DW-1:0]  ent_data
);

    logic [DEPTH-1:0][AW-1:0] addr_q, addr_d;
    logic [DEPTH-1:0][DW-1:0] data_q, data_d;
    logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]            count_q, count_d;
    logic                     do_push, do_pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        addr_d   = addr_q;
        data_d   = data_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            addr_d[wr_ptr_q] = wr_addr;
            data_d[wr_ptr_q] = wr_data;
            wr_ptr_d         = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q   <= '0;
            data_q   <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            addr_q   <= addr_d;
            data_q   <= data_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // A slot is live when its distance from the read pointer is below the count.
    always_comb begin
        logic [PW-1:0] offset;
        ent_valid = '0;
        offset    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset       = PW'(i) - rd_ptr_q;
            ent_valid[i] = ({1'b0, offset} < count_q);
        end
    end

    assign head_addr = addr_q[rd_ptr_q];
    assign head_data = data_q[rd_ptr_q];
    assign count     = count_q;
    assign rd_ptr    = rd_ptr_q;
    assign ent_addr  = addr_q;
    assign ent_data  = data_q;

endmodule

// File: rtl/store_handler.sv
// rtl/store_handler.sv - write-back stage: buffers ALU results and drains them to data memory on grant
module store_handler
    import dsd_pkg::*;
#(
    parameter int DATA_WIDTH       = 8,
    parameter int DATA_MEMORY_SIZE = 64,
    parameter int QUEUE_DEPTH      = 4,
    localparam int AW              = addr_width(DATA_MEMORY_SIZE),
    localparam int PW              = $clog2(QUEUE_DEPTH),
    localparam int CW              = PW + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] result_in,
    input  logic [AW-1:0]         dst_in,
    input  logic                  mem_grant,
    input  logic [AW-1:0]         chk_addr,
    output logic                  mem_we,
    output logic [AW-1:0]         mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  chk_hit,
    output logic [DATA_WIDTH-1:0] chk_data,
    output logic                  full,
    output logic                  idle,
    output logic                  done,
    output logic                  overflow
);

    logic                               push_req, push_ok, pop_ok;
    logic [AW-1:0]                      head_addr;
    logic [DATA_WIDTH-1:0]              head_data;
    logic [CW-1:0]                      q_count;
    logic                               q_full, q_empty;
    logic [PW-1:0]                      q_rd_ptr;
    logic [QUEUE_DEPTH-1:0]             ent_valid;
    logic [QUEUE_DEPTH-1:0][AW-1:0]     ent_addr;
    logic [QUEUE_DEPTH-1:0][DATA_WIDTH-1:0] ent_data;

    state_e                state_q, state_d;
    logic                  mem_we_q, mem_we_d;
    logic [AW-1:0]         mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;
    logic                  last_issue_q, last_issue_d;
    logic                  done_q, done_d;
    logic                  overflow_q, overflow_d;

    assign push_req = enable && valid_in;
    assign push_ok  = push_req && !q_full;
    assign pop_ok   = mem_grant && !q_empty;

    store_queue #(
        .AW    (AW),
        .DW    (DATA_WIDTH),
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (push_ok),
        .pop       (pop_ok),
        .wr_addr   (dst_in),
        .wr_data   (result_in),
        .head_addr (head_addr),
        .head_data (head_data),
        .count     (q_count),
        .full      (q_full),
        .empty     (q_empty),
        .rd_ptr    (q_rd_ptr),
        .ent_valid (ent_valid),
        .ent_addr  (ent_addr),
        .ent_data  (ent_data)
    );

    // done trails the final issue by one cycle, so it is staged through last_issue.
    always_comb begin
        state_d      = state_q;
        last_issue_d = 1'b0;
        done_d       = last_issue_q;
        mem_we_d     = pop_ok;
        mem_addr_d   = pop_ok ? head_addr : mem_addr_q;
        mem_data_d   = pop_ok ? head_data : mem_data_q;
        overflow_d   = overflow_q || (push_req && q_full);
        case (state_q)
            ST_IDLE: begin
                if (push_ok) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pop_ok && (q_count == CW'(1)) && !push_ok) begin
                    state_d      = ST_IDLE;
                    last_issue_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            last_issue_q <= 1'b0;
            done_q       <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            last_issue_q <= last_issue_d;
            done_q       <= done_d;
            overflow_q   <= overflow_d;
        end
    end

    // Walk entries oldest to youngest so the youngest match overrides; the
    // in-flight word only wins when no queued entry matches.
    always_comb begin
        logic [PW-1:0] idx;
        chk_hit  = 1'b0;
        chk_data = '0;
        idx      = '0;
        if (mem_we_q && (mem_addr_q == chk_addr)) begin
            chk_hit  = 1'b1;
            chk_data = mem_data_q;
        end
        for (int k = 0; k < QUEUE_DEPTH; k++) begin
            idx = q_rd_ptr + PW'(k);
            if (ent_valid[idx] && (ent_addr[idx] == chk_addr)) begin
                chk_hit  = 1'b1;
                chk_data = ent_data[idx];
            end
        end
    end

    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign mem_data = mem_data_q;
    assign full     = q_full;
    assign idle     = q_empty && !mem_we_q;
    assign done     = done_q;
    assign overflow = overflow_q;

endmodule

// File: doc/store_handler.md
Name: store_handler

Overview:
Write-back stage of the datapath, on the opposite side of data memory from the operand-load stage. It accepts ALU results with their destination addresses, buffers them in a small queue, and drains them to the shared single-port data memory whenever the memory arbiter grants the port. It also provides address-match forwarding, so the load stage never reads a location that still has a pending store.

Parameters:
DATA_WIDTH, 8, width of one data-memory word
DATA_MEMORY_SIZE, 64, number of data-memory words; address width AW = $clog2(DATA_MEMORY_SIZE)
QUEUE_DEPTH, 4, pending-store entries; power of two, at least 2

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
enable  in  1  stage enable; gates acceptance of new results only
valid_in  in  1  result_in/dst_in valid this cycle
result_in  in  DATA_WIDTH  ALU result
dst_in  in  AW  destination address
mem_grant  in  1  arbiter grants the memory port to this block this cycle
chk_addr  in  AW  address the load stage is about to read
mem_we  out  1  registered write strobe to data memory
mem_addr  out  AW  registered write address
mem_data  out  DATA_WIDTH  registered write data
chk_hit  out  1  combinational: chk_addr matches a pending or in-flight store
chk_data  out  DATA_WIDTH  combinational: data of the youngest matching store
full  out  1  queue holds QUEUE_DEPTH entries
idle  out  1  queue empty and mem_we low
done  out  1  one-cycle pulse when the last pending store is issued
overflow  out  1  sticky: a valid result was dropped because the queue was full

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high. On reset: queue count, read pointer and write pointer are 0; state is IDLE; mem_we=0, mem_addr=0, mem_data=0, done=0, overflow=0. After reset, full=0, idle=1, chk_hit=0 and chk_data=0.
- Push: accepted when enable && valid_in && !full. The entry {dst_in, result_in} is written at the write pointer, which increments modulo QUEUE_DEPTH.
- Drop: enable && valid_in && full. The entry is dropped, overflow is set and stays set until reset. No push is accepted into a full queue, even in a cycle where a pop also occurs.
- enable low: pushes are blocked; draining continues, so disabling the stage flushes it.
- Pop: when count>0 && mem_grant, the head entry is registered onto mem_addr/mem_data with mem_we=1 for exactly one cycle, and the read pointer increments modulo QUEUE_DEPTH. In every other cycle mem_we=0; mem_addr and mem_data hold their last values.
- Latency:
  - A result pushed at edge N, with an empty queue and grant high, gives mem_we=1 after edge N+1.
  - The memory commits the word at edge N+2.
  - At most one issue per cycle.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- State machine:
  - IDLE (count==0). A push goes to DRAIN.
  - DRAIN (count>0). On a pop that makes count 0 with no simultaneous push, return to IDLE and assert done=1 for the next cycle. Lack of mem_grant stalls in DRAIN without limit.
- Forwarding:
  - chk_hit=1 if any valid queue entry has addr==chk_addr, or if mem_we && mem_addr==chk_addr (the word is not yet committed).
  - chk_data priority, highest first: youngest matching queue entry, oldest matching queue entry, then the in-flight mem_data.
  - A result being pushed in the same cycle is not visible until the next cycle.
  - With no match, chk_data=0.
- Duplicate addresses in the queue are legal. Stores are issued in program order, so the last write wins in memory.
- Reset in the middle of a drain discards all pending stores. mem_we is 0 in the cycle after the reset edge.

Decomposition:
- Shared package dsd_pkg holds: address-width function, the store-entry type {addr, data}, and the IDLE/DRAIN state encoding.
- One natural sub-module: store_queue. It is a circular FIFO with count, full and empty, plus per-entry valid and contents exposed for the forwarding compare.
- store_handler contains the FSM, the output registers and the forwarding priority logic.

Test Plan:
- Reset, then push {dst=5, data=0x3C} with grant high -> mem_we=1, mem_addr=5, mem_data=0x3C exactly one cycle later; done pulses one cycle after that; idle=1 afterwards.
- Grant low, push 4 results to addresses 1,2,3,4 -> full=1; a fifth push to address 9 -> dropped, overflow=1; grant high -> writes issue in order 1,2,3,4 on consecutive cycles, followed by a single done pulse.
- Queue {7:0x11, 7:0x22} with grant low, chk_addr=7 -> chk_hit=1, chk_data=0x22; chk_addr=8 -> chk_hit=0, chk_data=0.
- Last entry for address 7 issued (mem_we=1, addr 7, data 0x22) with the queue now empty -> chk_addr=7 gives chk_hit=1, chk_data=0x22 in that cycle, and chk_hit=0 the next cycle.
- Queue at count 2 with grant high, then push each cycle -> count stays 2 and full never asserts; write order matches push order.
- Queue 3 entries, assert reset during the drain -> mem_we=0, idle=1, overflow=0 next cycle; no further writes issued.
